sequenciador_varredura: RTL and testbench
=========================================

SEQUENCIADOR_VARREDURA -- requirements
Module: sequenciador_varredura

Interface
REQ-001 Parameter: DIV_WIDTH, default 8, width of the prescaler period input and internal prescaler counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  synchronous pulse; begins a scan from OCIOSO.
REQ-005 stop  input  1  synchronous abort; returns to OCIOSO.
REQ-006 en  input  1  run/pause; low freezes prescaler and index while in VARRE.
REQ-007 dir  input  1  0 = ascending index, 1 = descending; sampled only on accepted start.
REQ-008 modo  input  1  0 = free-run with wrap, 1 = one-shot; sampled only on accepted start.
REQ-009 div  input  DIV_WIDTH  dwell period minus one, in clk cycles per index.
REQ-010 sel  output  3  select code for the downstream 3x8 decoder; sel[0] is the MSB of the index.
REQ-011 hab  output  1  decoder enable; high while scanning.
REQ-012 tick  output  1  one-cycle pulse in the first cycle sel shows a new index.
REQ-013 done  output  1  one-cycle pulse at completion of a one-shot scan.
REQ-014 ocupado  output  1  high in VARRE and FIM.

Function
REQ-015 Internal 3-bit index idx; sel SHALL equal {idx[0], idx[1], idx[2]} (sel[2]=idx[0], sel[0]=idx[2]) so decoder output y[idx] is the active line.
REQ-016 States: OCIOSO, VARRE, FIM; all outputs registered.
REQ-017 OCIOSO: start=1 and stop=0 -> VARRE next edge; idx loaded 0 (dir=0) or 7 (dir=1); prescaler cleared; dir/modo latched; tick=1 that cycle.
REQ-018 VARRE: hab=1, ocupado=1; start ignored.
REQ-019 VARRE, en=1: prescaler increments each cycle; when prescaler >= div, prescaler clears and idx steps +1 (dir latched 0) or -1 (latched 1), with tick=1 in the cycle the new sel appears.
REQ-020 div=0: idx steps every enabled cycle; general dwell per index = div+1 enabled cycles.
REQ-021 div reduced mid-dwell below current prescaler value: step on the next enabled cycle (>= compare).
REQ-022 VARRE, en=0: prescaler, idx, sel frozen; hab stays 1; tick=0.
REQ-023 Free-run (modo latched 0): 7->0 ascending, 0->7 descending, wrap, no done.
REQ-024 One-shot (modo latched 1): at a step due from the last index (7 ascending, 0 descending), go to FIM instead of stepping; idx unchanged.
REQ-025 FIM: done=1, hab=0, tick=0, ocupado=1 for exactly one cycle, then OCIOSO.
REQ-026 stop=1 in VARRE or FIM: OCIOSO next edge; no done; idx retained; hab=0.
REQ-027 start and stop same cycle: stop wins; start ignored.
REQ-028 OCIOSO: hab=0, tick=0, done=0, ocupado=0; sel holds last idx.

Reset
REQ-029 rst_n=0 SHALL immediately, independent of clk, force state OCIOSO, idx=0, prescaler=0, sel=000, hab=0, tick=0, done=0, ocupado=0, latched dir=0, latched modo=0.
REQ-030 Reset mid-scan SHALL abort with no done pulse; first start after release behaves as from power-up.

Verification
REQ-031 div=0, dir=0, modo=0, en=1, start pulse -> sel sequence 000,100,010,110,001,101,011,111,000 on consecutive cycles, tick every cycle, hab=1.
REQ-032 div=2, dir=1, modo=1, start -> idx 7..0 each held 3 cycles, then one cycle FIM with done=1, hab=0, then ocupado=0.
REQ-033 div=3, en dropped 5 cycles mid-dwell -> sel frozen, no tick; resumes with remaining dwell preserved.
REQ-034 start and stop asserted together in OCIOSO -> stays OCIOSO; stop during VARRE at idx=5 -> hab=0 next cycle, sel=101 held, no done.
REQ-035 rst_n low mid-scan between clock edges -> outputs cleared immediately; after release, start with dir=1 begins at sel=111.
REQ-036 div changed 7->1 when prescaler=4 -> step on next enabled cycle, then dwell of 2 cycles.

Source files
------------

// File: rtl/sequenciador_varredura.sv
// sequenciador_varredura -- 8-position scan sequencer driving a 3x8 decoder.
// Latency: start -> first index on sel one edge later; each index dwells div+1 enabled cycles.
// Backpressure: none; i_en pauses the scan and i_stop aborts it on the next edge.
//
// Ports:
//   i_clk        single clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      pulse, begins a scan from idle (ignored while scanning)
//   i_stop       abort back to idle; wins over i_start
//   i_en         run/pause while scanning
//   i_dir        0 = ascending, 1 = descending (captured on accepted start)
//   i_modo       0 = free-run with wrap, 1 = one-shot (captured on accepted start)
//   i_div        dwell period minus one, in clock cycles per index
//   o_sel        decoder select, bit-reversed index (o_sel[0] = idx[2])
//   o_hab        decoder enable, high while scanning
//   o_tick       one-cycle pulse in the first cycle a new index is shown
//   o_done       one-cycle pulse when a one-shot scan completes
//   o_ocupado    high while scanning or finishing
module sequenciador_varredura #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_en,
  input  logic                 i_dir,
  input  logic                 i_modo,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic [2:0]           o_sel,
  output logic                 o_hab,
  output logic                 o_tick,
  output logic                 o_done,
  output logic                 o_ocupado
);

  localparam logic [1:0] S_OCIOSO = 2'd0;
  localparam logic [1:0] S_VARRE  = 2'd1;
  localparam logic [1:0] S_FIM    = 2'd2;

  localparam logic [DIV_WIDTH-1:0] PRESC_ONE = DIV_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [1:0]           r_state;
  logic [2:0]           r_idx;
  logic [DIV_WIDTH-1:0] r_presc;
  logic                 r_dir;
  logic                 r_modo;
  logic                 r_hab;
  logic                 r_tick;
  logic                 r_done;
  logic                 r_ocupado;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  logic [1:0]           w_state_nxt;
  logic [2:0]           w_idx_nxt;
  logic [DIV_WIDTH-1:0] w_presc_nxt;
  logic                 w_dir_nxt;
  logic                 w_modo_nxt;
  logic                 w_tick_nxt;
  logic                 w_done_nxt;

  logic                 w_due;
  logic                 w_last;
  logic [2:0]           w_idx_step;

  // A step is due once the prescaler reaches div; ">=" rather than "==" so a
  // div lowered below the running count still steps on the next enabled cycle.
  assign w_due = (r_presc >= i_div);

  // Last index of the sweep in the captured direction.
  assign w_last = r_dir ? (r_idx == 3'd0) : (r_idx == 3'd7);

  // 3-bit arithmetic wraps naturally: 7+1 -> 0 and 0-1 -> 7.
  assign w_idx_step = r_dir ? (r_idx - 3'd1) : (r_idx + 3'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_presc_nxt = r_presc;
    w_dir_nxt   = r_dir;
    w_modo_nxt  = r_modo;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_OCIOSO: begin
        if (i_start && !i_stop) begin
          w_state_nxt = S_VARRE;
          w_idx_nxt   = i_dir ? 3'd7 : 3'd0;
          w_presc_nxt = '0;
          w_dir_nxt   = i_dir;
          w_modo_nxt  = i_modo;
          w_tick_nxt  = 1'b1;
        end
      end

      S_VARRE: begin
        if (i_stop) begin
          // Abort: index is kept so sel keeps showing where the scan stopped.
          w_state_nxt = S_OCIOSO;
        end else if (i_en) begin
          if (w_due) begin
            w_presc_nxt = '0;
            if (r_modo && w_last) begin
              // One-shot end: finish without moving off the last index.
              w_state_nxt = S_FIM;
              w_done_nxt  = 1'b1;
            end else begin
              w_idx_nxt  = w_idx_step;
              w_tick_nxt = 1'b1;
            end
          end else begin
            w_presc_nxt = r_presc + PRESC_ONE;
          end
        end
      end

      S_FIM: begin
        // FIM always lasts one cycle; stop here has the same outcome.
        w_state_nxt = S_OCIOSO;
      end

      default: begin
        w_state_nxt = S_OCIOSO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential update; outputs derive from the next state so they are registered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_OCIOSO;
      r_idx     <= 3'd0;
      r_presc   <= '0;
      r_dir     <= 1'b0;
      r_modo    <= 1'b0;
      r_hab     <= 1'b0;
      r_tick    <= 1'b0;
      r_done    <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_presc   <= w_presc_nxt;
      r_dir     <= w_dir_nxt;
      r_modo    <= w_modo_nxt;
      r_hab     <= (w_state_nxt == S_VARRE);
      r_tick    <= w_tick_nxt;
      r_done    <= w_done_nxt;
      r_ocupado <= (w_state_nxt != S_OCIOSO);
    end
  end

  // Bit-reversed wiring of the index register: the decoder's select LSB is
  // the index MSB, so y[idx] ends up being the active line.
  assign o_sel     = {r_idx[0], r_idx[1], r_idx[2]};
  assign o_hab     = r_hab;
  assign o_tick    = r_tick;
  assign o_done    = r_done;
  assign o_ocupado = r_ocupado;

endmodule

// File: tb/tb_sequenciador_varredura.sv
// tb_sequenciador_varredura -- directed bench for the scan sequencer.
// Latency: inputs driven 1ns after a rising edge, outputs sampled at the same point.
// Backpressure: n/a; all waits are fixed cycle counts.
module tb_sequenciador_varredura;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_stop;
  logic       i_en;
  logic       i_dir;
  logic       i_modo;
  logic [7:0] i_div;
  logic [2:0] o_sel;
  logic       o_hab;
  logic       o_tick;
  logic       o_done;
  logic       o_ocupado;

  int n_checks;
  int n_pass;

  sequenciador_varredura #(.DIV_WIDTH(8)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .i_en      (i_en),
    .i_dir     (i_dir),
    .i_modo    (i_modo),
    .i_div     (i_div),
    .o_sel     (o_sel),
    .o_hab     (o_hab),
    .o_tick    (o_tick),
    .o_done    (o_done),
    .o_ocupado (o_ocupado)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge and settle 1ns past it.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] sel, input logic hab,
                         input logic tick, input logic done, input logic ocp);
    chk({tag, ".sel"},  {5'd0, o_sel},     {5'd0, sel});
    chk({tag, ".hab"},  {7'd0, o_hab},     {7'd0, hab});
    chk({tag, ".tick"}, {7'd0, o_tick},    {7'd0, tick});
    chk({tag, ".done"}, {7'd0, o_done},    {7'd0, done});
    chk({tag, ".ocp"},  {7'd0, o_ocupado}, {7'd0, ocp});
  endtask

  task automatic pulse_start(input logic d, input logic m, input logic [7:0] dv);
    i_dir = d; i_modo = m; i_div = dv; i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic do_stop();
    i_stop = 1'b1;
    cyc();
    i_stop = 1'b0;
  endtask

  // Hand-written sel sequences (bit-reversed index).
  logic [2:0] seq_up [9];
  logic [2:0] seq_dn [8];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    seq_up = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111, 3'b000};
    seq_dn = '{3'b111, 3'b011, 3'b101, 3'b001, 3'b110, 3'b010, 3'b100, 3'b000};

    i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_en = 1'b1;
    i_dir = 1'b0; i_modo = 1'b0; i_div = 8'd0;
    #1;
    chk_out("reset", 3'b000, 0, 0, 0, 0);
    cyc(); cyc();
    i_rst_n = 1'b1;
    cyc();
    chk_out("idle_after_reset", 3'b000, 0, 0, 0, 0);

    // Free-run ascending, div=0: new index every cycle, wraps 7->0.
    pulse_start(1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 9; k++) begin
      chk_out($sformatf("up_div0[%0d]", k), seq_up[k], 1, 1, 0, 1);
      cyc();
    end
    do_stop();
    chk_out("up_div0_stopped", 3'b100, 0, 0, 0, 0);

    // One-shot descending, div=2: each index held 3 cycles, then FIM.
    pulse_start(1'b1, 1'b1, 8'd2);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 3; c++) begin
        chk_out($sformatf("dn_os[%0d.%0d]", k, c), seq_dn[k], 1, (c == 0), 0, 1);
        cyc();
      end
    end
    chk_out("dn_os_fim", 3'b000, 0, 0, 1, 1);
    cyc();
    chk_out("dn_os_idle", 3'b000, 0, 0, 0, 0);
    cyc();
    chk_out("dn_os_idle2", 3'b000, 0, 0, 0, 0);

    // Pause mid-dwell with div=3: remaining dwell preserved.
    pulse_start(1'b0, 1'b0, 8'd3);
    chk_out("pause_p0", 3'b000, 1, 1, 0, 1);
    cyc();
    chk_out("pause_p1", 3'b000, 1, 0, 0, 1);
    i_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_out($sformatf("pause_frozen[%0d]", k), 3'b000, 1, 0, 0, 1);
    end
    i_en = 1'b1;
    cyc();
    chk_out("pause_p2", 3'b000, 1, 0, 0, 1);
    cyc();
    chk_out("pause_p3", 3'b000, 1, 0, 0, 1);
    cyc();
    chk_out("pause_step", 3'b100, 1, 1, 0, 1);
    do_stop();

    // start and stop together in idle: stop wins.
    i_start = 1'b1; i_stop = 1'b1; i_div = 8'd0;
    cyc();
    i_start = 1'b0; i_stop = 1'b0;
    chk_out("start_stop_idle", 3'b100, 0, 0, 0, 0);
    cyc();
    chk_out("start_stop_idle2", 3'b100, 0, 0, 0, 0);

    // Stop during VARRE at idx=5.
    pulse_start(1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 5; k++) cyc();
    chk_out("run_to_5", 3'b101, 1, 1, 0, 1);
    do_stop();
    chk_out("stop_at_5", 3'b101, 0, 0, 0, 0);
    cyc();
    chk_out("stop_at_5_hold", 3'b101, 0, 0, 0, 0);

    // Free-run descending wraps 0->7 with no done.
    pulse_start(1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 8; k++) cyc();
    chk_out("dn_wrap", 3'b111, 1, 1, 0, 1);
    do_stop();

    // div lowered 7->1 while prescaler is 4.
    pulse_start(1'b0, 1'b0, 8'd7);
    for (int k = 0; k < 4; k++) cyc();
    chk_out("div_chg_pre", 3'b000, 1, 0, 0, 1);
    i_div = 8'd1;
    cyc();
    chk_out("div_chg_step", 3'b100, 1, 1, 0, 1);
    cyc();
    chk_out("div_chg_dwell", 3'b100, 1, 0, 0, 1);
    cyc();
    chk_out("div_chg_step2", 3'b010, 1, 1, 0, 1);
    do_stop();

    // Asynchronous reset between edges, then restart descending.
    pulse_start(1'b0, 1'b1, 8'd0);
    cyc(); cyc(); cyc();
    chk_out("pre_reset", 3'b110, 1, 1, 0, 1);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk_out("async_reset", 3'b000, 0, 0, 0, 0);
    cyc();
    i_rst_n = 1'b1;
    cyc();
    chk_out("post_reset_idle", 3'b000, 0, 0, 0, 0);
    pulse_start(1'b1, 1'b0, 8'd0);
    chk_out("restart_dn", 3'b111, 1, 1, 0, 1);
    cyc();
    chk_out("restart_dn2", 3'b011, 1, 1, 0, 1);
    do_stop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
